// File: rtl/nacp_pkg.sv
// Shared NACP definitions: MAC/command field layout, responder FSM states and
// the reply metadata packing.
package nacp_pkg;
    localparam int MAC_W       = 48;
    localparam int CMD_TYPE_HI = 63;
    localparam int CMD_TYPE_LO = 61;
    localparam int CMD_SUCC    = 60;
    localparam int CMD_WR      = 59;
    localparam int CMD_MOD_HI  = 58;
    localparam int CMD_MOD_LO  = 52;
    localparam int CMD_ADDR_HI = 51;
    localparam int CMD_ADDR_LO = 32;
    localparam int CMD_DATA_HI = 31;
    localparam int CMD_DATA_LO = 0;

    localparam int          MD_OUT_W   = 112;
    localparam logic [1:0]  MD_OUT_TAG = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_TOSEND = 2'd2
    } state_e;

    // Reply metadata: tag, port field, 64-bit timestamp field, low 30 bits.
    function automatic logic [MD_OUT_W-1:0] build_md(input logic [255:0] md);
        return {MD_OUT_TAG, md[79:64], md[255:192], md[29:0]};
    endfunction
endpackage

// File: rtl/nacp_result_responder_if.sv
// Request/result/reply bus of the NACP result responder.
interface nacp_result_responder_if
    import nacp_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int MD_W   = 256,
    parameter int RES_W  = 64
);
    logic [DATA_W+7:0]   req_in;
    logic                req_in_wr;
    logic [MD_W-1:0]     req_md_in;
    logic                req_md_in_wr;
    logic                req_in_alf;
    logic [RES_W-1:0]    result_in;
    logic                result_wr;
    logic                result_alf;
    logic [DATA_W+7:0]   pkt_out;
    logic                pkt_out_wr;
    logic [MD_OUT_W-1:0] md_out;
    logic                md_out_wr;
    logic                pkt_out_alf;

    modport master (
        output req_in, req_in_wr, req_md_in, req_md_in_wr, result_in, result_wr, pkt_out_alf,
        input  req_in_alf, result_alf, pkt_out, pkt_out_wr, md_out, md_out_wr
    );
    modport slave (
        input  req_in, req_in_wr, req_md_in, req_md_in_wr, result_in, result_wr, pkt_out_alf,
        output req_in_alf, result_alf, pkt_out, pkt_out_wr, md_out, md_out_wr
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO; a write to a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 128,
    parameter int ALF_MARGIN = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_N,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       d,
    input  logic                   rd,
    output logic [WIDTH-1:0]       q,
    output logic                   empty,
    output logic                   full,
    output logic                   alf,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr_ok, rd_ok;

    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign q     = mem[rp];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign alf   = (count >= (AW+1)'(DEPTH - ALF_MARGIN));

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wp] <= d;
    end
endmodule

// File: rtl/nacp_result_responder.sv
// Pairs buffered NACP request flits with config-path results and emits reply
// control packets; requests starved of a result get a failure reply.
module nacp_result_responder
    import nacp_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int MD_W       = 256,
    parameter int RES_W      = 64,
    parameter int DEPTH      = 128,
    parameter int ALF_MARGIN = 8,
    parameter int CMD_LSB    = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                   Clk,
    input  logic                   Reset_N,
    nacp_result_responder_if.slave bus,
    output logic [31:0]            pkt_out_cnt,
    output logic [31:0]            result_in_cnt,
    output logic [31:0]            timeout_cnt,
    output logic [31:0]            ovf_cnt
);
    localparam int FW = DATA_W + 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FW-1:0]    req_q, reply_d;
    logic [MD_W-1:0]  md_q;
    logic [RES_W-1:0] res_q, cmd_new;
    logic             req_empty, req_full, req_alf;
    logic             md_empty, md_full, md_alf;
    logic             res_empty, res_full, res_alf;
    logic [CW-1:0]    req_lvl, md_lvl, res_lvl;
    logic             ready, go_send, go_to, pop_req, pop_res, res_acc;
    logic [1:0]       n_drop;
    logic [32:0]      ovf_sum;
    logic [31:0]      to_cnt;
    state_e           state_q, state_d;
    logic             unused_bits;

    sync_fifo_fwft #(.WIDTH(FW), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) u_req_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .wr(bus.req_in_wr), .d(bus.req_in), .rd(pop_req),
        .q(req_q), .empty(req_empty), .full(req_full), .alf(req_alf), .count(req_lvl));
    sync_fifo_fwft #(.WIDTH(MD_W), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) u_md_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .wr(bus.req_md_in_wr), .d(bus.req_md_in), .rd(pop_req),
        .q(md_q), .empty(md_empty), .full(md_full), .alf(md_alf), .count(md_lvl));
    sync_fifo_fwft #(.WIDTH(RES_W), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) u_res_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .wr(bus.result_wr), .d(bus.result_in), .rd(pop_res),
        .q(res_q), .empty(res_empty), .full(res_full), .alf(res_alf), .count(res_lvl));

    // Fill levels and the metadata bits not carried into the reply are not needed here.
    assign unused_bits = ^{req_lvl, md_lvl, res_lvl, md_q};

    assign bus.req_in_alf = req_alf || md_alf;
    assign bus.result_alf = res_alf;

    always_comb begin
        ready          = !req_empty && !md_empty && !bus.pkt_out_alf;
        go_send        = ready && !res_empty;
        go_to          = ready && res_empty && (TIMEOUT != 0) && (to_cnt == 32'(TIMEOUT - 1));
        pop_req        = go_send || go_to;
        pop_res        = go_send;
        state_d        = ST_IDLE;
        if (go_send)    state_d = ST_SEND;
        else if (go_to) state_d = ST_TOSEND;
        bus.pkt_out_wr = (state_q != ST_IDLE);
        bus.md_out_wr  = (state_q != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Swap MACs; the command word is the result on success, the original with success cleared on timeout.
    always_comb begin
        reply_d                              = req_q;
        reply_d[DATA_W-1 -: MAC_W]           = req_q[DATA_W-MAC_W-1 -: MAC_W];
        reply_d[DATA_W-MAC_W-1 -: MAC_W]     = req_q[DATA_W-1 -: MAC_W];
        if (pop_res) begin
            cmd_new           = res_q;
            cmd_new[CMD_SUCC] = 1'b1;
        end else begin
            cmd_new           = req_q[CMD_LSB +: RES_W];
            cmd_new[CMD_SUCC] = 1'b0;
        end
        reply_d[CMD_LSB +: RES_W] = cmd_new;
    end

    assign res_acc = bus.result_wr && (!res_full || pop_res);
    assign n_drop  = 2'(bus.req_in_wr && req_full && !pop_req)
                   + 2'(bus.req_md_in_wr && md_full && !pop_req)
                   + 2'(bus.result_wr && res_full && !pop_res);
    assign ovf_sum = {1'b0, ovf_cnt} + 33'(n_drop);

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            bus.pkt_out   <= '0;
            bus.md_out    <= '0;
            to_cnt        <= '0;
            pkt_out_cnt   <= '0;
            result_in_cnt <= '0;
            timeout_cnt   <= '0;
            ovf_cnt       <= '0;
        end else begin
            if (pop_req) begin
                bus.pkt_out <= reply_d;
                bus.md_out  <= build_md(md_q[255:0]);
            end
            if (pop_req || req_empty)             to_cnt <= '0;
            else if (!bus.pkt_out_alf && res_empty) to_cnt <= to_cnt + 32'd1;
            if (bus.pkt_out_wr) pkt_out_cnt   <= pkt_out_cnt + 32'd1;
            if (res_acc)        result_in_cnt <= result_in_cnt + 32'd1;
            if (go_to)          timeout_cnt   <= timeout_cnt + 32'd1;
            ovf_cnt <= ovf_sum[32] ? '1 : ovf_sum[31:0];
        end
    end
endmodule

// File: tb/tb_nacp_result_responder.sv
// Bench for nacp_result_responder: scoreboarded replies, table-driven burst,
// back-pressure, timeout, overflow and mid-burst reset sequences.
module tb_nacp_result_responder;
    localparam int DW = 512;
    localparam int MW = 256;
    localparam int RW = 64;
    localparam int FW = DW + 8;

    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    always #5 Clk = ~Clk;

    nacp_result_responder_if #(.DATA_W(DW), .MD_W(MW), .RES_W(RW)) a_if();
    nacp_result_responder_if #(.DATA_W(DW), .MD_W(MW), .RES_W(RW)) b_if();
    logic [31:0] a_pcnt, a_rcnt, a_tcnt, a_ocnt, b_pcnt, b_rcnt, b_tcnt, b_ocnt;

    nacp_result_responder #(.DATA_W(DW), .MD_W(MW), .RES_W(RW), .DEPTH(128), .ALF_MARGIN(8),
                            .CMD_LSB(0), .TIMEOUT(16)) u_dut_a (
        .Clk(Clk), .Reset_N(Reset_N), .bus(a_if), .pkt_out_cnt(a_pcnt),
        .result_in_cnt(a_rcnt), .timeout_cnt(a_tcnt), .ovf_cnt(a_ocnt));
    nacp_result_responder #(.DATA_W(DW), .MD_W(MW), .RES_W(RW), .DEPTH(8), .ALF_MARGIN(2),
                            .CMD_LSB(0), .TIMEOUT(0)) u_dut_b (
        .Clk(Clk), .Reset_N(Reset_N), .bus(b_if), .pkt_out_cnt(b_pcnt),
        .result_in_cnt(b_rcnt), .timeout_cnt(b_tcnt), .ovf_cnt(b_ocnt));

    typedef struct { logic [FW-1:0] pkt; logic [111:0] md; } exp_t;
    typedef struct { logic [RW-1:0] res; logic [RW-1:0] cmd_exp; } vec_t;

    exp_t sbq[$];
    exp_t e;
    vec_t vt[10];
    int   nchk = 0;
    int   nbad = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rnd_bits();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom();
        return t[FW-1:0];
    endfunction

    function automatic logic [MW-1:0] rnd_md();
        logic [MW-1:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    function automatic logic [FW-1:0] mk_req(input logic [7:0] hdr, input logic [47:0] dst,
                                              input logic [47:0] src, input logic [63:0] cmd);
        logic [FW-1:0] f;
        f = rnd_bits();
        f[FW-1 -: 8]  = hdr;
        f[DW-1 -: 48] = dst;
        f[DW-49 -: 48] = src;
        f[63:0]       = cmd;
        return f;
    endfunction

    function automatic logic [FW-1:0] exp_pkt(input logic [FW-1:0] r, input logic [63:0] cmd);
        logic [FW-1:0] f;
        f = r;
        f[DW-1 -: 48]  = r[DW-49 -: 48];
        f[DW-49 -: 48] = r[DW-1 -: 48];
        f[63:0]        = cmd;
        return f;
    endfunction

    function automatic logic [111:0] exp_md(input logic [MW-1:0] m);
        return {2'b10, m[79:64], m[255:192], m[29:0]};
    endfunction

    function automatic logic [63:0] with_succ(input logic [63:0] c);
        logic [63:0] v;
        v = c;
        v[60] = 1'b1;
        return v;
    endfunction

    task automatic a_drive(input bit rq, input logic [FW-1:0] r, input logic [MW-1:0] m,
                           input bit rs, input logic [RW-1:0] res);
        a_if.req_in       = r;
        a_if.req_in_wr    = rq;
        a_if.req_md_in    = m;
        a_if.req_md_in_wr = rq;
        a_if.result_in    = res;
        a_if.result_wr    = rs;
        tick();
        a_if.req_in_wr    = 1'b0;
        a_if.req_md_in_wr = 1'b0;
        a_if.result_wr    = 1'b0;
    endtask

    task automatic b_drive(input bit rq, input bit mw);
        b_if.req_in       = rnd_bits();
        b_if.req_in_wr    = rq;
        b_if.req_md_in    = rnd_md();
        b_if.req_md_in_wr = mw;
        tick();
        b_if.req_in_wr    = 1'b0;
        b_if.req_md_in_wr = 1'b0;
    endtask

    // Reply monitor: every strobe must match the oldest expected reply.
    always @(negedge Clk) begin
        if (Reset_N && a_if.pkt_out_wr === 1'b1) begin
            if (sbq.size() == 0) begin
                nchk++;
                nbad++;
                $display("FAIL reply_unexpected: got reply %0h want none", a_if.pkt_out);
            end else begin
                e = sbq.pop_front();
                chk("reply_pkt", a_if.pkt_out, e.pkt);
                chk("reply_md", FW'(a_if.md_out), FW'(e.md));
                chk("reply_md_wr", FW'(a_if.md_out_wr), FW'(1'b1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary want summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] r, rq[10];
        logic [MW-1:0] m, mq[10];
        logic [RW-1:0] rv;
        int n;

        vt[0] = '{64'h0000_0000_0000_0001, 64'h1000_0000_0000_0001};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[2] = '{64'hE000_0000_0000_0000, 64'hF000_0000_0000_0000};
        vt[3] = '{64'h2345_6789_ABCD_EF01, 64'h3345_6789_ABCD_EF01};
        vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
        vt[5] = '{64'h8000_0000_FFFF_0000, 64'h9000_0000_FFFF_0000};
        vt[6] = '{64'h4C00_1234_0000_5555, 64'h5C00_1234_0000_5555};
        vt[7] = '{64'h6A5A_5A5A_5A5A_5A5A, 64'h7A5A_5A5A_5A5A_5A5A};
        vt[8] = '{64'hC0FF_EE00_0000_0000, 64'hD0FF_EE00_0000_0000};
        vt[9] = '{64'h0EAD_BEEF_0000_0042, 64'h1EAD_BEEF_0000_0042};

        a_if.req_in = '0; a_if.req_in_wr = 1'b0; a_if.req_md_in = '0; a_if.req_md_in_wr = 1'b0;
        a_if.result_in = '0; a_if.result_wr = 1'b0; a_if.pkt_out_alf = 1'b0;
        b_if.req_in = '0; b_if.req_in_wr = 1'b0; b_if.req_md_in = '0; b_if.req_md_in_wr = 1'b0;
        b_if.result_in = '0; b_if.result_wr = 1'b0; b_if.pkt_out_alf = 1'b0;

        // Reset state
        #12;
        chk("rst_pkt_wr", FW'(a_if.pkt_out_wr), FW'(1'b0));
        chk("rst_md_wr", FW'(a_if.md_out_wr), FW'(1'b0));
        chk("rst_pkt", a_if.pkt_out, '0);
        chk("rst_md", FW'(a_if.md_out), '0);
        chk("rst_cnts", FW'({a_pcnt, a_rcnt, a_tcnt, a_ocnt}), '0);
        chk("rst_alf", FW'({a_if.req_in_alf, a_if.result_alf}), '0);
        @(posedge Clk); #1;
        Reset_N = 1'b1;
        tick();

        // Single request, result three cycles later
        r = mk_req(8'h5A, 48'h1122_3344_5566, 48'hAABB_CCDD_EEFF, 64'hA000_0000_0000_0000);
        m = rnd_md();
        a_drive(1'b1, r, m, 1'b0, '0);
        tick();
        tick();
        sbq.push_back('{pkt: exp_pkt(r, 64'hB010_0001_DEAD_BEEF), md: exp_md(m)});
        a_drive(1'b0, r, m, 1'b1, 64'hA010_0001_DEAD_BEEF);
        chk("t1_no_early", FW'(a_if.pkt_out_wr), FW'(1'b0));
        tick();
        chk("t1_wr", FW'(a_if.pkt_out_wr), FW'(1'b1));
        chk("t1_cmd", FW'(a_if.pkt_out[63:0]), FW'(64'hB010_0001_DEAD_BEEF));
        chk("t1_dst", FW'(a_if.pkt_out[DW-1 -: 48]), FW'(48'hAABB_CCDD_EEFF));
        chk("t1_src", FW'(a_if.pkt_out[DW-49 -: 48]), FW'(48'h1122_3344_5566));
        chk("t1_md_tag", FW'(a_if.md_out[111:110]), FW'(2'b10));
        tick();
        chk("t1_idle", FW'(a_if.pkt_out_wr), FW'(1'b0));
        chk("t1_pcnt", FW'(a_pcnt), FW'(32'd1));

        // Ten requests, then ten results back to back
        for (int i = 0; i < 10; i++) begin
            rq[i] = mk_req(8'(8'h40 + i), 48'(48'h0100_0000_0000 + i), 48'(48'h0200_0000_0000 + i),
                           {$urandom(), $urandom()});
            mq[i] = rnd_md();
            a_drive(1'b1, rq[i], mq[i], 1'b0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            sbq.push_back('{pkt: exp_pkt(rq[i], vt[i].cmd_exp), md: exp_md(mq[i])});
            a_drive(1'b0, rq[i], mq[i], 1'b1, vt[i].res);
            chk($sformatf("t2_wr%0d", i), FW'(a_if.pkt_out_wr), FW'(i > 0));
        end
        tick();
        chk("t2_wr_last", FW'(a_if.pkt_out_wr), FW'(1'b1));
        tick();
        chk("t2_end", FW'(a_if.pkt_out_wr), FW'(1'b0));
        chk("t2_pcnt", FW'(a_pcnt), FW'(32'd11));

        // Downstream back-pressure holds four matched pairs
        a_if.pkt_out_alf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r  = mk_req(8'h77, 48'(48'h0300_0000_0000 + i), 48'(48'h0400_0000_0000 + i), 64'h0);
            m  = rnd_md();
            rv = 64'h2000_0000_0000_0000 | 64'(i);
            sbq.push_back('{pkt: exp_pkt(r, with_succ(rv)), md: exp_md(m)});
            a_drive(1'b1, r, m, 1'b1, rv);
            chk($sformatf("t3_hold_w%0d", i), FW'(a_if.pkt_out_wr), FW'(1'b0));
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3_hold%0d", k), FW'(a_if.pkt_out_wr), FW'(1'b0));
        end
        a_if.pkt_out_alf = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_wr%0d", k), FW'(a_if.pkt_out_wr), FW'(1'b1));
            tick();
        end
        chk("t3_end", FW'(a_if.pkt_out_wr), FW'(1'b0));

        // Timeout failure reply, then a late result stays queued
        r = mk_req(8'hE1, 48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 64'hF5A5_0000_1234_5678);
        m = rnd_md();
        sbq.push_back('{pkt: exp_pkt(r, 64'hE5A5_0000_1234_5678), md: exp_md(m)});
        a_drive(1'b1, r, m, 1'b0, '0);
        n = 0;
        while (a_if.pkt_out_wr !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_latency", FW'(n), FW'(16));
        chk("t4_succ_bit", FW'(a_if.pkt_out[60]), FW'(1'b0));
        chk("t4_tcnt", FW'(a_tcnt), FW'(32'd1));
        tick();
        a_drive(1'b0, r, m, 1'b1, 64'h0000_0000_0000_0077);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_queued%0d", k), FW'(a_if.pkt_out_wr), FW'(1'b0));
            tick();
        end
        r = mk_req(8'h3C, 48'h0000_1111_2222, 48'h3333_4444_5555, 64'h0123_4567_89AB_CDEF);
        m = rnd_md();
        sbq.push_back('{pkt: exp_pkt(r, 64'h1000_0000_0000_0077), md: exp_md(m)});
        a_drive(1'b1, r, m, 1'b0, '0);
        tick();
        chk("t4_pair_wr", FW'(a_if.pkt_out_wr), FW'(1'b1));
        tick();
        chk("t4_tcnt_hold", FW'(a_tcnt), FW'(32'd1));
        chk("t4_rcnt", FW'(a_rcnt), FW'(32'd16));
        chk("t4_pcnt", FW'(a_pcnt), FW'(32'd17));

        // Small FIFO: almost-full threshold and overflow accounting
        for (int i = 1; i <= 9; i++) begin
            b_drive(1'b1, 1'b0);
            chk($sformatf("t5_alf%0d", i), FW'(b_if.req_in_alf), FW'(i >= 6));
        end
        chk("t5_ovf1", FW'(b_ocnt), FW'(32'd1));
        for (int i = 0; i < 8; i++) b_drive(1'b0, 1'b1);
        chk("t5_ovf_md_fill", FW'(b_ocnt), FW'(32'd1));
        b_drive(1'b1, 1'b1);
        chk("t5_ovf_pair", FW'(b_ocnt), FW'(32'd3));
        chk("t5_no_timeout", FW'({b_pcnt, b_tcnt}), '0);

        // Reset in the middle of a reply burst
        a_if.pkt_out_alf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r  = mk_req(8'h99, 48'(48'h0500_0000_0000 + i), 48'(48'h0600_0000_0000 + i), 64'h0);
            m  = rnd_md();
            rv = 64'h4000_0000_0000_00A0 | 64'(i);
            sbq.push_back('{pkt: exp_pkt(r, with_succ(rv)), md: exp_md(m)});
            a_drive(1'b1, r, m, 1'b1, rv);
        end
        a_if.pkt_out_alf = 1'b0;
        tick();
        tick();
        #2;
        Reset_N = 1'b0;
        #1;
        chk("t6_wr", FW'({a_if.pkt_out_wr, a_if.md_out_wr}), '0);
        chk("t6_pkt", a_if.pkt_out, '0);
        chk("t6_md", FW'(a_if.md_out), '0);
        chk("t6_cnts", FW'({a_pcnt, a_rcnt, a_tcnt, a_ocnt}), '0);
        sbq.delete();
        @(posedge Clk); #1;
        Reset_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_idle%0d", k), FW'(a_if.pkt_out_wr), FW'(1'b0));
        end
        a_drive(1'b0, r, m, 1'b1, 64'h0000_0000_0000_0555);
        tick();
        chk("t6_res_only", FW'(a_if.pkt_out_wr), FW'(1'b0));
        r = mk_req(8'h11, 48'h0700_0000_0001, 48'h0800_0000_0001, 64'h0);
        m = rnd_md();
        sbq.push_back('{pkt: exp_pkt(r, 64'h1000_0000_0000_0555), md: exp_md(m)});
        a_drive(1'b1, r, m, 1'b0, '0);
        tick();
        chk("t6_fresh_wr", FW'(a_if.pkt_out_wr), FW'(1'b1));
        tick();
        chk("t6_pcnt", FW'(a_pcnt), FW'(32'd1));
        tick();
        chk("sb_drained", FW'(sbq.size()), '0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
